// File: rtl/uart_dev_if.sv
// uart_dev_if: bridge-side device-slot bus for the UART peripheral
//   ADR_I  4   byte address (0x0 DATA, 0x4 STATUS, 0x8 CTRL)
//   STB_I  1   device select
//   WE_I   1   1 = write, 0 = read
//   DAT_I  32  write data, only [7:0] used
//   DAT_O  8   read data
//   ACK_O  1   zero-wait-state acknowledge
interface uart_dev_if;
    logic [3:0]  ADR_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [7:0]  DAT_O;
    logic        ACK_O;
    modport master(output ADR_I, STB_I, WE_I, DAT_I, input DAT_O, ACK_O);
    modport slave(input ADR_I, STB_I, WE_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/uart_dev.sv
// uart_dev: 8N1 UART peripheral with fixed baud divisor and level interrupt
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   bus    slave device-slot bus (DATA / STATUS / CTRL registers)
//   rxd    in   serial input, asynchronous to clk
//   txd    out  serial output, idle high
//   irq    out  level interrupt: (rxie & rx_valid) | (txie & ~tx_busy), registered
module uart_dev #(
    parameter int unsigned DIV  = 5208,
    parameter int unsigned HALF = DIV / 2
) (
    input  logic       clk,
    input  logic       reset,
    uart_dev_if.slave  bus,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;
    localparam logic [15:0] DIV1  = 16'(DIV - 1);
    localparam logic [15:0] HALF1 = 16'(HALF - 1);
    tx_state_t   tx_st;
    rx_state_t   rx_st;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh, rx_data;
    logic [1:0]  ctrl;
    logic        rx_s1, rxs, rx_valid, overrun, frame_err;
    logic        wr_data, wr_ctrl, rd_data, rd_stat, tx_busy, tx_load, rx_end, rx_ok, rx_bad;
    logic        unused_hi;
    assign wr_data = bus.STB_I & bus.WE_I & (bus.ADR_I == 4'h0);
    assign wr_ctrl = bus.STB_I & bus.WE_I & (bus.ADR_I == 4'h8);
    assign rd_data = bus.STB_I & ~bus.WE_I & (bus.ADR_I == 4'h0);
    assign rd_stat = bus.STB_I & ~bus.WE_I & (bus.ADR_I == 4'h4);
    assign tx_busy = tx_st != TX_IDLE;
    // A write landing on the edge that ends STOP starts the next frame with no idle gap.
    assign tx_load = wr_data & (tx_st == TX_IDLE || (tx_st == TX_STOP && tx_cnt == 16'd0));
    assign rx_end  = rx_st == RX_STOP && rx_cnt == 16'd0;
    assign rx_ok   = rx_end & rxs;
    assign rx_bad  = rx_end & ~rxs;
    assign unused_hi = ^bus.DAT_I[31:8];
    assign bus.ACK_O = bus.STB_I;
    assign bus.DAT_O = !bus.STB_I ? 8'h00 :
                       bus.ADR_I == 4'h0 ? rx_data :
                       bus.ADR_I == 4'h4 ? {4'b0, frame_err, overrun, rx_valid, tx_busy} :
                       bus.ADR_I == 4'h8 ? {6'b0, ctrl} : 8'h00;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            txd    <= 1'b1;
        end else if (tx_load) begin
            tx_st  <= TX_START;
            tx_sh  <= bus.DAT_I[7:0];
            tx_cnt <= DIV1;
            txd    <= 1'b0;
        end else if (tx_st != TX_IDLE) begin
            if (tx_cnt != 16'd0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else begin
                tx_cnt <= DIV1;
                case (tx_st)
                    TX_START: begin
                        tx_st  <= TX_DATA;
                        tx_bit <= 3'd0;
                        txd    <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                    end
                    TX_DATA: begin
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            tx_st <= TX_STOP;
                            txd   <= 1'b1;
                        end else begin
                            txd   <= tx_sh[0];
                            tx_sh <= tx_sh >> 1;
                        end
                    end
                    default: tx_st <= TX_IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_st)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_st  <= RX_START;
                        rx_cnt <= HALF1;
                    end
                end
                // Line stuck low after a framing error: wait for idle before re-arming.
                RX_HOLD: if (rxs) rx_st <= RX_IDLE;
                default: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_cnt <= DIV1;
                        case (rx_st)
                            RX_START: begin
                                rx_st  <= rxs ? RX_IDLE : RX_DATA;
                                rx_bit <= 3'd0;
                            end
                            RX_DATA: begin
                                rx_sh  <= {rxs, rx_sh[7:1]};
                                rx_bit <= rx_bit + 3'd1;
                                if (rx_bit == 3'd7) rx_st <= RX_STOP;
                            end
                            default: rx_st <= rxs ? RX_IDLE : RX_HOLD;
                        endcase
                    end
                end
            endcase
        end
    end
    // Flag updates: a completing event wins over a simultaneous clearing read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1     <= 1'b1;
            rxs       <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            ctrl      <= '0;
            irq       <= 1'b0;
        end else begin
            rx_s1     <= rxd;
            rxs       <= rx_s1;
            rx_data   <= rx_ok ? rx_sh : rx_data;
            rx_valid  <= rx_ok | (rx_valid & ~rd_data);
            overrun   <= (rx_ok & rx_valid & ~rd_data) | (overrun & ~rd_data);
            frame_err <= rx_bad | (frame_err & ~rd_stat);
            ctrl      <= wr_ctrl ? bus.DAT_I[1:0] : ctrl;
            irq       <= (ctrl[0] & rx_valid) | (ctrl[1] & ~tx_busy);
        end
    end
endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev: self-checking bench for uart_dev at DIV=16 with a byte-level reference model
module tb_uart_dev;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxd = 1'b1;
    logic txd, irq;
    int checks = 0;
    int failures = 0;
    logic [7:0] got, exp;
    logic [7:0] m_data = 8'h00;
    logic m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    uart_dev_if bus();
    uart_dev #(.DIV(16)) dut(.clk(clk), .reset(reset), .bus(bus), .rxd(rxd), .txd(txd), .irq(irq));
    always #5 clk = ~clk;
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    function automatic logic [7:0] m_status();
        return {4'b0, m_ferr, m_ovr, m_valid, 1'b0};
    endfunction
    task automatic m_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask
    task automatic start_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ADR_I = a;
        bus.DAT_I = {24'($urandom), d};
        bus.WE_I = 1'b1;
        bus.STB_I = 1'b1;
        @(posedge clk);
        #1;
        bus.STB_I = 1'b0;
        bus.WE_I = 1'b0;
    endtask
    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.ADR_I = a;
        bus.WE_I = 1'b0;
        bus.STB_I = 1'b1;
        #1 d = bus.DAT_O;
        @(posedge clk);
        #1;
        bus.STB_I = 1'b0;
    endtask
    task automatic read_data_model();
        bus_read(4'h0, got);
        exp = m_data; m_valid = 1'b0; m_ovr = 1'b0;
    endtask
    task automatic read_status_model();
        bus_read(4'h4, got);
        exp = m_status(); m_ferr = 1'b0;
    endtask
    // Drives one serial frame on rxd and applies the frame's effect to the model.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd = fr[k];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data = b;
        end else m_ferr = 1'b1;
    endtask
    // Samples txd at each bit mid-point measured from the write edge; pos0 = cycles already elapsed.
    task automatic watch_tx(input logic [7:0] b, input int pos0, input logic tail);
        logic [9:0] fr;
        int pos;
        fr = {1'b1, b, 1'b0};
        pos = pos0;
        bus.ADR_I = 4'h4;
        bus.WE_I = 1'b0;
        bus.STB_I = 1'b1;
        #0;
        if (pos0 == 0) begin
            checks++;
            if (txd !== 1'b0 || bus.DAT_O[0] !== 1'b1) begin
                failures++;
                $display("FAIL tx_start: txd=%b busy=%b required txd=0 busy=1", txd, bus.DAT_O[0]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (16 * k + 8 > pos) begin
                repeat (16 * k + 8 - pos) @(posedge clk);
                #1;
                pos = 16 * k + 8;
                checks++;
                if (txd !== fr[k] || bus.DAT_O[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_bit%0d byte %h: txd=%b busy=%b required txd=%b busy=1",
                             k, b, txd, bus.DAT_O[0], fr[k]);
                end
            end
        end
        if (tail) begin
            repeat (159 - pos) @(posedge clk);
            #1;
            checks++;
            if (bus.DAT_O[0] !== 1'b1 || txd !== 1'b1) begin
                failures++;
                $display("FAIL tx_busy_last: busy=%b txd=%b required 1 1", bus.DAT_O[0], txd);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.DAT_O[0] !== 1'b0 || txd !== 1'b1) begin
                failures++;
                $display("FAIL tx_busy_clear: busy=%b txd=%b required 0 1", bus.DAT_O[0], txd);
            end
        end
        bus.STB_I = 1'b0;
    endtask
    task automatic test_reset();
        bus.STB_I = 1'b0; bus.WE_I = 1'b0; bus.ADR_I = 4'h0; bus.DAT_I = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_pins: txd=%b irq=%b required 1 0", txd, irq);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), got);
            checks++;
            if (got !== 8'h00) begin
                failures++;
                $display("FAIL reset_read adr %h: got %h required 00", a, got);
            end
        end
        start_write(4'hC, 8'hFF);
        bus_read(4'h8, got);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL unmapped_write: CTRL=%h required 00", got);
        end
        @(negedge clk);
        bus.ADR_I = 4'h8; bus.STB_I = 1'b1;
        #1;
        checks++;
        if (bus.ACK_O !== 1'b1) begin
            failures++;
            $display("FAIL ack_high: ack=%b required 1", bus.ACK_O);
        end
        bus.STB_I = 1'b0;
        #1;
        checks++;
        if (bus.ACK_O !== 1'b0 || bus.DAT_O !== 8'h00) begin
            failures++;
            $display("FAIL idle_bus: ack=%b dat=%h required 0 00", bus.ACK_O, bus.DAT_O);
        end
    endtask
    task automatic test_tx();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            start_write(4'h0, b);
            watch_tx(b, 0, 1'b1);
        end
    endtask
    task automatic test_back_to_back();
        start_write(4'h0, 8'h12);
        repeat (19) @(posedge clk);
        start_write(4'h0, 8'h34);
        watch_tx(8'h12, 20, 1'b0);
        repeat (7) @(posedge clk);
        start_write(4'h0, 8'h34);
        watch_tx(8'h34, 0, 1'b1);
    endtask
    task automatic test_rx();
        logic [7:0] b;
        int op;
        send_rx(8'h3C, 1'b1);
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h02) begin
            failures++;
            $display("FAIL rx_3c_status: got %h required %h", got, exp);
        end
        read_data_model();
        checks++;
        if (got !== exp || got !== 8'h3C) begin
            failures++;
            $display("FAIL rx_3c_data: got %h required %h", got, exp);
        end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_rx(b, $urandom_range(0, 3) != 0);
            op = $urandom_range(0, 2);
            if (op == 0) read_data_model();
            else if (op == 1) read_status_model();
            if (op != 2) begin
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rx_rand%0d op%0d: got %h required %h", i, op, got, exp);
                end
            end
        end
        read_status_model();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rx_drain_status: got %h required %h", got, exp);
        end
        read_data_model();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rx_drain_data: got %h required %h", got, exp);
        end
    endtask
    task automatic test_overrun();
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h06) begin
            failures++;
            $display("FAIL overrun_status: got %h required %h", got, exp);
        end
        read_data_model();
        checks++;
        if (got !== exp || got !== 8'h22) begin
            failures++;
            $display("FAIL overrun_data: got %h required %h", got, exp);
        end
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h00) begin
            failures++;
            $display("FAIL overrun_cleared: got %h required %h", got, exp);
        end
    endtask
    task automatic test_glitch_framing();
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h00) begin
            failures++;
            $display("FAIL glitch_status: got %h required %h", got, exp);
        end
        send_rx(8'h55, 1'b0);
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h08) begin
            failures++;
            $display("FAIL frame_err_status: got %h required %h", got, exp);
        end
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h00) begin
            failures++;
            $display("FAIL frame_err_cleared: got %h required %h", got, exp);
        end
        send_rx(8'h96, 1'b1);
        read_data_model();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL after_frame_err_data: got %h required %h", got, exp);
        end
    endtask
    task automatic test_irq();
        logic [7:0] b;
        start_write(4'h8, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_rx_idle: irq=%b required 0", irq);
        end
        b = 8'($urandom);
        send_rx(b, 1'b1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rx_rise: irq=%b required 1", irq);
        end
        read_data_model();
        checks++;
        if (got !== exp || irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rx_read: data=%h irq=%b required data=%h irq=1", got, irq, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_rx_fall: irq=%b required 0", irq);
        end
        start_write(4'h8, 8'h02);
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_tx_idle: irq=%b required 1", irq);
        end
        start_write(4'h0, 8'h81);
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_tx_busy: irq=%b required 0", irq);
        end
        repeat (165) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_tx_done: irq=%b required 1", irq);
        end
        start_write(4'h8, 8'h00);
    endtask
    task automatic test_reset_midframe();
        logic [7:0] b;
        send_rx(8'hE7, 1'b1);
        start_write(4'h0, 8'h00);
        @(negedge clk);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_txd: txd=%b required 0", txd);
        end
        #2 reset = 1'b0;
        bus.ADR_I = 4'h4; bus.WE_I = 1'b0; bus.STB_I = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || bus.DAT_O !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: txd=%b status=%h irq=%b required 1 00 0", txd, bus.DAT_O, irq);
        end
        bus.STB_I = 1'b0;
        rxd = 1'b1;
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        b = 8'($urandom);
        send_rx(b, 1'b1);
        read_status_model();
        checks++;
        if (got !== exp || got !== 8'h02) begin
            failures++;
            $display("FAIL post_reset_status: got %h required %h", got, exp);
        end
        read_data_model();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL post_reset_data: got %h required %h", got, exp);
        end
    endtask
    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_glitch_framing();
        test_irq();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
